// File: rtl/hack_pkg.sv
// Shared definitions for the Hack ALU arbiter: ALU control bit positions,
// the control word type, common opcodes and the arbiter FSM state encoding.
package hack_pkg;

    localparam int ZX = 5;
    localparam int NX = 4;
    localparam int ZY = 3;
    localparam int NY = 2;
    localparam int F  = 1;
    localparam int NO = 0;

    typedef logic [5:0] alu_ctl_t;

    localparam alu_ctl_t CTL_AND = 6'b000000;
    localparam alu_ctl_t CTL_ADD = 6'b000010;
    localparam alu_ctl_t CTL_OR  = 6'b010101;
    localparam alu_ctl_t CTL_X   = 6'b001100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: zero/negate each input, And or Add, optional output
// negate, plus zero and negative flags on the final result.
module hack_alu
    import hack_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  alu_ctl_t         i_ctl,
    output logic [WIDTH-1:0] o_out,
    output logic             o_zr,
    output logic             o_ng
);

    logic [WIDTH-1:0] w_x1;
    logic [WIDTH-1:0] w_x2;
    logic [WIDTH-1:0] w_y1;
    logic [WIDTH-1:0] w_y2;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_o;

    assign w_x1  = i_ctl[ZX] ? '0 : i_x;
    assign w_x2  = i_ctl[NX] ? ~w_x1 : w_x1;
    assign w_y1  = i_ctl[ZY] ? '0 : i_y;
    assign w_y2  = i_ctl[NY] ? ~w_y1 : w_y1;
    assign w_and = w_x2 & w_y2;
    // Carry out of the adder is intentionally dropped (modulo 2^WIDTH).
    assign w_sum = w_x2 + w_y2;
    assign w_o   = i_ctl[F] ? w_sum : w_and;
    assign o_out = i_ctl[NO] ? ~w_o : w_o;
    assign o_zr  = (o_out == '0);
    assign o_ng  = o_out[WIDTH-1];

endmodule

// File: rtl/hack_alu_arbiter.sv
// Round-robin arbiter sharing one Hack ALU among NREQ requesters: capture
// operands on accept, compute for one cycle, hold the result on a valid/ready port.
module hack_alu_arbiter
    import hack_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    input  logic [NREQ*6-1:0]     req_ctl,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_zr,
    output logic                  rsp_ng
);

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    alu_ctl_t         r_ctl;
    logic [IDW-1:0]   r_id;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_zr;
    logic             r_rsp_ng;

    logic [WIDTH-1:0] w_x [NREQ];
    logic [WIDTH-1:0] w_y [NREQ];
    alu_ctl_t         w_ctl [NREQ];
    logic             w_grant_found;
    logic [IDW-1:0]   w_grant_idx;
    logic [IDW-1:0]   w_scan_idx;
    logic [IDW-1:0]   w_next_ptr;
    logic [NREQ-1:0]  w_req_ready;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_zr;
    logic             w_alu_ng;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_x[i]   = req_x[i*WIDTH +: WIDTH];
            w_y[i]   = req_y[i*WIDTH +: WIDTH];
            w_ctl[i] = req_ctl[i*6 +: 6];
        end
    end

    // Scan starts at the round-robin pointer; first valid requester wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_grant_found && req_valid[w_scan_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (r_state == ST_IDLE && w_grant_found) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_next_ptr = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

    hack_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_x   (r_x),
        .i_y   (r_y),
        .i_ctl (r_ctl),
        .o_out (w_alu_out),
        .o_zr  (w_alu_zr),
        .o_ng  (w_alu_ng)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_ctl       <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_zr    <= 1'b0;
            r_rsp_ng    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_found) begin
                        r_x      <= w_x[w_grant_idx];
                        r_y      <= w_y[w_grant_idx];
                        r_ctl    <= w_ctl[w_grant_idx];
                        r_id     <= w_grant_idx;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= w_alu_out;
                    r_rsp_zr    <= w_alu_zr;
                    r_rsp_ng    <= w_alu_ng;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_zr    = r_rsp_zr;
    assign rsp_ng    = r_rsp_ng;

endmodule

// File: tb/tb_hack_alu_arbiter.sv
// Scoreboard bench for hack_alu_arbiter: a predictor pushes expected responses
// at accept time, a monitor pops and compares when responses appear.
module tb_hack_alu_arbiter;
    import hack_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    typedef struct {
        logic [WIDTH+IDW+1:0] bits;   // {data, id, zr, ng}
        int                   cyc;
    } exp_t;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic [NREQ*6-1:0]     req_ctl;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_zr;
    logic                  rsp_ng;

    logic [WIDTH-1:0] tb_x [NREQ];
    logic [WIDTH-1:0] tb_y [NREQ];
    logic [5:0]       tb_ctl [NREQ];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];
    bit   busy  = 0;
    int   ptr   = 0;

    hack_alu_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ctl   (req_ctl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_zr    (rsp_zr),
        .rsp_ng    (rsp_ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*WIDTH +: WIDTH] = tb_x[i];
            req_y[i*WIDTH +: WIDTH] = tb_y[i];
            req_ctl[i*6 +: 6]       = tb_ctl[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU written with integer arithmetic: complement is 0xFFFF - v.
    function automatic int ref_alu(input int x, input int y, input logic [5:0] c);
        int a, b, o;
        a = c[5] ? 0 : x;
        if (c[4]) a = 65535 - a;
        b = c[3] ? 0 : y;
        if (c[2]) b = 65535 - b;
        o = c[1] ? (a + b) % 65536 : (a & b);
        if (c[0]) o = 65535 - o;
        return o;
    endfunction

    // Predictor: knows the arbiter is free when no op is outstanding and
    // grants the first valid requester from the round-robin pointer.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int   g, d;
        exp_t e;
        if (reset) begin
            busy = 0;
            ptr  = 0;
            sb.delete();
        end else begin
            g = -1;
            exp_rdy = '0;
            if (!busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (g >= 0) begin
                d = ref_alu(int'(tb_x[g]), int'(tb_y[g]), tb_ctl[g]);
                e.bits = {d[WIDTH-1:0], g[IDW-1:0], (d == 0), (d >= 32768)};
                e.cyc  = cyc + 2;
                sb.push_back(e);
                ptr  = (g + 1) % NREQ;
                busy = 1;
            end else if (busy && rsp_valid && rsp_ready) begin
                busy = 0;
            end
        end
    end

    // Monitor: pops on each new response, checks stability while held.
    always @(negedge clk) begin
        static bit                   prev_v = 0;
        static bit                   prev_r = 0;
        static logic [WIDTH+IDW+1:0] held   = '0;
        logic [WIDTH+IDW+1:0]        act;
        exp_t                        e;
        act = {rsp_data, rsp_id, rsp_zr, rsp_ng};
        if (reset) begin
            check("reset_outputs", 64'({rsp_valid, act}), 64'(0));
            prev_v = 0;
        end else begin
            if (rsp_valid && !(prev_v && !prev_r)) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(act), 64'(~act));
                end else begin
                    e = sb.pop_front();
                    check("rsp_data_id_zr_ng", 64'(act), 64'(e.bits));
                    check("rsp_latency", 64'(cyc), 64'(e.cyc));
                end
                held = act;
            end else if (rsp_valid) begin
                check("rsp_stable", 64'(act), 64'(held));
            end
            prev_v = rsp_valid;
            prev_r = rsp_ready;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || sb.size() != 0) && t < 60) begin
            step(1);
            t++;
        end
        if (busy || sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: %0d responses still pending after %0d cycles", sb.size(), t);
        end
    endtask

    task automatic issue(input int r, input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        tb_x[r] = x;
        tb_y[r] = y;
        tb_ctl[r] = c;
        req_valid = '0;
        req_valid[r] = 1'b1;
        step(1);
        req_valid = '0;
    endtask

    initial begin
        reset = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            tb_x[i] = '0;
            tb_y[i] = '0;
            tb_ctl[i] = '0;
        end
        step(2);
        reset = 1'b0;
        rsp_ready = 1'b1;
        step(1);

        // All requesters valid continuously: grants rotate 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) begin
            tb_x[i] = 16'(i * 16'h0101);
            tb_y[i] = 16'h0F0F;
            tb_ctl[i] = CTL_ADD;
        end
        req_valid = '1;
        step(15);
        req_valid = '0;
        wait_idle();

        issue(0, 16'h00F0, 16'h0FF0, CTL_AND);
        wait_idle();
        issue(3, 16'hFFFF, 16'h0001, CTL_ADD);
        wait_idle();
        issue(3, 16'h7FFF, 16'h0001, CTL_ADD);
        wait_idle();

        // Consumer stalls in HOLD; result must stay put and nothing is granted.
        rsp_ready = 1'b0;
        issue(2, 16'hA5A5, 16'h1234, CTL_X);
        req_valid = '1;
        step(7);
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        // Reset while the op is in EXEC: no response, pointer back to 0.
        issue(0, 16'h1111, 16'h2222, CTL_ADD);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        issue(2, 16'h0042, 16'h0001, CTL_ADD);
        wait_idle();

        // Operand changes after accept must not affect the result.
        tb_x[1] = 16'h1200;
        tb_y[1] = 16'h0034;
        tb_ctl[1] = CTL_OR;
        req_valid = 4'b0010;
        step(1);
        req_valid = '0;
        tb_x[1] = 16'hFFFF;
        tb_y[1] = 16'hFFFF;
        tb_ctl[1] = CTL_AND;
        wait_idle();

        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                tb_x[i] = 16'($urandom);
                tb_y[i] = 16'($urandom);
                case ($urandom_range(0, 4))
                    0:       tb_ctl[i] = CTL_AND;
                    1:       tb_ctl[i] = CTL_ADD;
                    2:       tb_ctl[i] = CTL_OR;
                    3:       tb_ctl[i] = CTL_X;
                    default: tb_ctl[i] = 6'($urandom_range(0, 63));
                endcase
            end
            step(1);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
